// File: rtl/nic_pkg.sv
// ============================================================================
// Module   : nic_pkg
// Purpose  : Shared packet format, type codes and tx-state encoding for the
//            ring NIC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nic_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [1:0] PT_NULL = 2'd0;
    localparam logic [1:0] PT_DATA = 2'd1;
    localparam logic [1:0] PT_CTRL = 2'd2;
    localparam logic [1:0] PT_ACK  = 2'd3;

    typedef struct packed {
        logic [1:0]  typ;
        logic [5:0]  did;
        logic [5:0]  sid;
        logic [5:0]  age;
        logic [15:0] data;
    } packet_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_PEND = 1'b1
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/nic_ring_node.sv
// ============================================================================
// Module   : nic_ring_node
// Purpose  : One stage of a slotted ring: delivers packets addressed here,
//            forwards and ages the rest, and injects local packets into
//            free slots.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nic_ring_node
    import nic_pkg::*;
#(
    parameter logic [5:0] NODE_ID = 6'd1,
    parameter logic [5:0] MAX_AGE = 6'd62
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  packet_t     pkt_i,
    output packet_t     pkt_o,
    input  logic        tx_req_i,
    input  packet_t     tx_pkt_i,
    output logic        tx_ack_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output packet_t     rx_pkt_o,
    output logic [15:0] drop_cnt_o
);

    tx_state_t   r_state;
    tx_state_t   w_next_state;
    packet_t     r_tx_pkt;
    packet_t     r_pkt_out;
    logic        r_tx_ack;
    logic        r_rx_valid;
    packet_t     r_rx_pkt;
    logic [15:0] r_drop_cnt;

    logic    w_is_null;
    logic    w_for_me;
    logic    w_rx_space;
    logic    w_rx_capture;
    logic    w_aged;
    logic    w_slot_free;
    logic    w_capture_tx;
    logic    w_inject;
    packet_t w_fwd_pkt;
    packet_t w_inj_pkt;
    packet_t w_out_pkt;

    // Slot classification for the packet currently arriving from upstream.
    always_comb begin
        w_is_null    = (pkt_i.typ == PT_NULL);
        w_for_me     = !w_is_null && (pkt_i.did == NODE_ID);
        w_rx_space   = !r_rx_valid || rx_ready_i;
        w_rx_capture = w_for_me && w_rx_space;
        // Anything that would be forwarded (including recirculated own
        // traffic) is subject to aging.
        w_aged       = !w_is_null && !w_rx_capture && (pkt_i.age >= MAX_AGE);
        w_slot_free  = w_is_null || w_rx_capture || w_aged;
    end

    always_comb begin
        w_fwd_pkt     = pkt_i;
        w_fwd_pkt.age = pkt_i.age + 6'd1;
        w_inj_pkt     = r_tx_pkt;
        w_inj_pkt.sid = NODE_ID;
        w_inj_pkt.age = 6'd0;
    end

    always_comb begin
        w_next_state = r_state;
        w_capture_tx = FALSE;
        w_inject     = FALSE;
        case (r_state)
            TX_IDLE: begin
                if (tx_req_i) begin
                    w_capture_tx = TRUE;
                    w_next_state = TX_PEND;
                end
            end
            TX_PEND: begin
                if (w_slot_free) begin
                    w_inject     = TRUE;
                    w_next_state = TX_IDLE;
                end
            end
            default: w_next_state = TX_IDLE;
        endcase
    end

    always_comb begin
        if (w_inject) begin
            w_out_pkt = w_inj_pkt;
        end else if (w_slot_free) begin
            w_out_pkt = '0;
        end else begin
            w_out_pkt = w_fwd_pkt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_pkt   <= '0;
            r_pkt_out  <= '0;
            r_tx_ack   <= FALSE;
            r_rx_valid <= FALSE;
            r_rx_pkt   <= '0;
            r_drop_cnt <= 16'd0;
        end else begin
            r_pkt_out <= w_out_pkt;
            r_tx_ack  <= w_capture_tx;
            if (w_capture_tx) begin
                r_tx_pkt <= tx_pkt_i;
            end
            // A same-cycle capture overrides the clear from a consumer accept.
            if (w_rx_capture) begin
                r_rx_valid <= TRUE;
                r_rx_pkt   <= pkt_i;
            end else if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= FALSE;
            end
            if (w_aged && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign pkt_o      = r_pkt_out;
    assign tx_ack_o   = r_tx_ack;
    assign rx_valid_o = r_rx_valid;
    assign rx_pkt_o   = r_rx_pkt;
    assign drop_cnt_o = r_drop_cnt;

endmodule

`default_nettype wire

// File: doc/nic_ring_node.md
NIC_RING_NODE -- requirements
Module: nic_ring_node

Interface
REQ-001 SHALL have parameter NODE_ID, default 6'd1, this node's ring address.
REQ-002 SHALL have parameter MAX_AGE, default 6'd62, the age at which a forwarded packet is discarded.
REQ-003 SHALL have port clk_i  input  1  sole clock.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port pkt_i  input  packet_t  packet from upstream ring stage, one per cycle.
REQ-006 SHALL have port pkt_o  output  packet_t  registered packet to downstream ring stage.
REQ-007 SHALL have port tx_req_i  input  1  local transmit request (level).
REQ-008 SHALL have port tx_pkt_i  input  packet_t  local packet; valid while tx_req_i=1.
REQ-009 SHALL have port tx_ack_o  output  1  one-cycle pulse: tx_pkt_i captured.
REQ-010 SHALL have port rx_valid_o  output  1  rx_pkt_o holds a packet addressed to this node.
REQ-011 SHALL have port rx_ready_i  input  1  local consumer accepts rx_pkt_o.
REQ-012 SHALL have port rx_pkt_o  output  packet_t  received packet.
REQ-013 SHALL have port drop_cnt_o  output  16  saturating count of aged-out packets.

Function
REQ-014 pkt_o SHALL be registered: the decision on pkt_i at cycle N appears on pkt_o at cycle N+1.
REQ-015 Tx FSM SHALL have states IDLE and PEND; in IDLE with tx_req_i=1, capture tx_pkt_i, pulse tx_ack_o, go to PEND.
REQ-016 In PEND, tx_req_i SHALL be ignored; return to IDLE on the cycle the held packet is injected; no capture occurs that same cycle.
REQ-017 Injected packet SHALL carry sid=NODE_ID, age=0, all other fields from the captured tx_pkt_i.
REQ-018 Per cycle, priority on pkt_i: (a) typ=PT_NULL -> slot free; (b) did=NODE_ID and rx space -> capture into rx, slot free; (c) did=NODE_ID and no rx space -> forward; (d) other -> forward.
REQ-019 Rx space SHALL exist when rx_valid_o=0 or (rx_valid_o=1 and rx_ready_i=1) in the same cycle.
REQ-020 A free slot SHALL take the PEND packet if any; otherwise pkt_o SHALL be all-zero (PT_NULL).
REQ-021 Forwarding SHALL increment age by 1; if incoming age >= MAX_AGE, the packet is discarded instead, the slot becomes free, and drop_cnt_o increments (saturating at 16'hFFFF).
REQ-022 A packet addressed to this node that is recirculated under REQ-018(c) SHALL also obey the aging rule.
REQ-023 rx_valid_o/rx_pkt_o SHALL stay stable until rx_ready_i=1; clear on accept unless a new capture happens the same cycle (then rx_pkt_o updates, rx_valid_o stays 1).
REQ-024 A packet with did=NODE_ID SHALL never be consumed into rx when rx is full; it SHALL not be dropped except by aging.

Reset
REQ-025 On rst_i=1 at a clk_i edge: pkt_o=0 (PT_NULL), rx_valid_o=0, rx_pkt_o=0, tx_ack_o=0, drop_cnt_o=0, tx FSM=IDLE.
REQ-026 Reset mid-operation SHALL discard any PEND and held rx packet without injecting or delivering it.

Structure
REQ-027 packet_t, PT_* codes, TRUE/FALSE SHALL come from nic_pkg; no new typedefs are needed beyond a tx-state enum, which SHALL also be placed in nic_pkg.
REQ-028 Implementation SHALL be a single module with no sub-modules; the aging/drop logic stays inline.

Verification
REQ-029 Null ring, tx_req_i=1 with did=5 -> tx_ack_o pulse next edge; injected packet on pkt_o with sid=1, age=0, within 2 cycles.
REQ-030 pkt_i did=1, rx_ready_i=0 twice -> first held on rx_pkt_o; second forwarded with age+1; rx_valid_o remains 1.
REQ-031 pkt_i did=7, age=62 -> pkt_o PT_NULL next cycle, drop_cnt_o=1; age=61 -> forwarded with age=62.
REQ-032 rx full, rx_ready_i=1, and did=1 arriving the same cycle -> new packet captured, rx_valid_o stays 1, nothing forwarded.
REQ-033 PEND while ring is full of did=9 traffic for 10 cycles, then PT_NULL -> injection into that slot; no tx_ack_o until the next request.
REQ-034 Assert rst_i while in PEND with rx held -> all outputs 0 next cycle; no later injection of the held packet.
